// File: rtl/conv_sequencer.sv
// MSDAP FIR convolution sequencer: one output sample per start, one channel per instance.
// Latency 49+3R cycles from accepted start to conv_done. Ignores start while busy; abort wins over everything.
// Optional: CONV_OVF_EN adds a sticky signed-overflow flag (ovf).
module conv_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  n_idx,
    output logic [3:0]  rj_addr,
    input  logic [7:0]  rj_rdata,
    output logic [8:0]  coeff_addr,
    input  logic [8:0]  coeff_rdata,
    output logic [7:0]  data_addr,
    input  logic [15:0] data_rdata,
    output logic        busy,
    output logic        conv_done,
`ifdef CONV_OVF_EN
    output logic [39:0] y_out,
    output logic        ovf
`else
    output logic [39:0] y_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_RJ_RD, S_RJ_WAIT, S_COEF_RD, S_COEF_WAIT, S_DATA_WAIT, S_SHIFT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [39:0] acc_q, acc_d;
    logic [39:0] y_q, y_d;
    logic [3:0]  j_q, j_d;
    logic [9:0]  cptr_q, cptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  n_q, n_d;
    logic        sign_q, sign_d;
    logic [39:0] ext;
    logic [39:0] sum;
    logic        cptr_end;

    assign ext      = {{8{data_rdata[15]}}, data_rdata, 16'b0};
    assign sum      = sign_q ? (acc_q - ext) : (acc_q + ext);
    assign cptr_end = (cptr_q == 10'd512);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            j_q     <= '0;
            cptr_q  <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            j_q     <= j_d;
            cptr_q  <= cptr_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_RJ_RD;
            S_RJ_RD:     state_d = S_RJ_WAIT;
            S_RJ_WAIT:   state_d = (rj_rdata == 8'd0 || cptr_end) ? S_SHIFT : S_COEF_RD;
            S_COEF_RD:   state_d = S_COEF_WAIT;
            S_COEF_WAIT: state_d = S_DATA_WAIT;
            S_DATA_WAIT: state_d = (cnt_q == 8'd1 || cptr_end) ? S_SHIFT : S_COEF_RD;
            S_SHIFT:     state_d = (j_q == 4'd15) ? S_DONE : S_RJ_RD;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        acc_d  = acc_q;
        y_d    = y_q;
        j_d    = j_q;
        cptr_d = cptr_q;
        cnt_d  = cnt_q;
        n_d    = n_q;
        sign_d = sign_q;
        case (state_q)
            S_IDLE: if (start) begin
                acc_d  = '0;
                j_d    = '0;
                cptr_d = '0;
                n_d    = n_idx;
            end
            S_RJ_WAIT:   cnt_d = rj_rdata;
            S_COEF_WAIT: begin
                sign_d = coeff_rdata[8];
                cptr_d = cptr_end ? cptr_q : cptr_q + 10'd1;
            end
            S_DATA_WAIT: begin
                acc_d = sum;
                cnt_d = cnt_q - 8'd1;
            end
            S_SHIFT: begin
                acc_d = {acc_q[39], acc_q[39:1]};
                j_d   = j_q + 4'd1;
            end
            S_DONE:  y_d = acc_q;
            default: ;
        endcase
        if (abort) begin
            acc_d = '0;
            y_d   = y_q;
        end
    end

    // y_out bypasses the register during DONE so it is valid alongside conv_done
    always_comb begin
        busy       = (state_q != S_IDLE);
        conv_done  = (state_q == S_DONE) && !abort;
        rj_addr    = j_q;
        coeff_addr = cptr_q[8:0];
        data_addr  = (state_q == S_COEF_WAIT) ? (n_q - coeff_rdata[7:0]) : 8'd0;
        y_out      = conv_done ? acc_q : y_q;
    end

`ifdef CONV_OVF_EN
    logic ovf_q, ovf_d;
    logic acc_ovf;

    assign acc_ovf = (sum[39] != acc_q[39]) &&
                     (sign_q ? (acc_q[39] != ext[39]) : (acc_q[39] == ext[39]));

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_IDLE && start) ovf_d = 1'b0;
        if (state_q == S_DATA_WAIT && acc_ovf) ovf_d = 1'b1;
        if (abort) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: synchronous memory models, directed plus random runs vs an arithmetic reference model.
module tb_conv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, abort;
    logic [7:0]  n_idx;
    logic [3:0]  rj_addr;
    logic [7:0]  rj_rdata;
    logic [8:0]  coeff_addr;
    logic [8:0]  coeff_rdata;
    logic [7:0]  data_addr;
    logic [15:0] data_rdata;
    logic        busy, conv_done;
    logic [39:0] y_out;
`ifdef CONV_OVF_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    conv_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .n_idx(n_idx),
        .rj_addr(rj_addr), .rj_rdata(rj_rdata),
        .coeff_addr(coeff_addr), .coeff_rdata(coeff_rdata),
        .data_addr(data_addr), .data_rdata(data_rdata),
        .busy(busy), .conv_done(conv_done),
`ifdef CONV_OVF_EN
        .y_out(y_out), .ovf(ovf)
`else
        .y_out(y_out)
`endif
    );

    logic [7:0]  rj_mem [16];
    logic [8:0]  co_mem [512];
    logic [15:0] d_mem  [256];

    always @(posedge clk) begin
        rj_rdata    <= rj_mem[rj_addr];
        coeff_rdata <= co_mem[coeff_addr];
        data_rdata  <= d_mem[data_addr];
    end

    int errors = 0;
    int checks = 0;

    logic [7:0]  daddr_log [0:2047];
    bit          busy_log  [0:2047];
    int          max_caddr;
    bit          ovf_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk groups and coefficient list with plain integer arithmetic.
    function automatic void model(input logic [7:0] n, output logic [39:0] y, output int r, output bit ov);
        logic signed [39:0] acc;
        longint e, t;
        logic [7:0] a;
        logic [15:0] x;
        int cp;
        acc = '0; cp = 0; ov = 1'b0;
        for (int g = 0; g < 16; g++) begin
            for (int c = 0; c < int'(rj_mem[g]) && cp < 512; c++) begin
                a = n - co_mem[cp][7:0];
                x = d_mem[a];
                e = longint'($signed(x)) * 65536;
                if (co_mem[cp][8]) e = -e;
                t = longint'(acc) + e;
                if (t > 64'sd549755813887 || t < -64'sd549755813888) ov = 1'b1;
                acc = t[39:0];
                cp++;
            end
            acc = acc >>> 1;
        end
        y = acc;
        r = cp;
    endfunction

    task automatic run(input logic [7:0] n, input int abort_cyc, input int restart_cyc,
                       output int done_cyc, output logic [39:0] y_done);
        @(negedge clk);
        start = 1'b1; n_idx = n;
        done_cyc = -1; y_done = '0; max_caddr = 0; ovf_done = 1'b0;
        for (int i = 0; i < 2048; i++) begin daddr_log[i] = '0; busy_log[i] = 1'b0; end
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            daddr_log[cyc] = data_addr;
            busy_log[cyc]  = busy;
            if (int'(coeff_addr) > max_caddr) max_caddr = int'(coeff_addr);
            if (conv_done) begin
                done_cyc = cyc;
                y_done   = y_out;
`ifdef CONV_OVF_EN
                ovf_done = ovf;
`endif
                break;
            end
            if (abort_cyc > 0 && cyc == abort_cyc + 60) break;
            start = (cyc == restart_cyc);
            n_idx = start ? ~n : n;
            abort = (cyc == abort_cyc);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++)  rj_mem[i] = '0;
        for (int i = 0; i < 512; i++) co_mem[i] = '0;
        for (int i = 0; i < 256; i++) d_mem[i]  = '0;
    endtask

    initial begin
        int dc, r;
        logic [39:0] yd, ym, yprev;
        bit ov;
        logic [7:0] n;

        clear_mem();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; n_idx = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", conv_done, 0);
        check("rst_y", y_out, 0);
        check("rst_rj_addr", rj_addr, 0);
        check("rst_coeff_addr", coeff_addr, 0);
        check("rst_data_addr", data_addr, 0);
        reset_n = 1'b1;

        // all groups empty
        run(8'h37, 0, 0, dc, yd);
        check("t1_latency", dc, 49);
        check("t1_y", yd, 40'h0);
        check("t1_caddr", max_caddr, 0);
        check("t1_busy_first", busy_log[1], 1);
        check("t1_busy_done", busy_log[49], 1);
        @(negedge clk);
        check("t1_busy_after", busy, 0);

        // single coefficient in group 0
        clear_mem();
        rj_mem[0] = 8'd1; co_mem[0] = 9'h000; d_mem[10] = 16'h4000;
        run(8'd10, 0, 0, dc, yd);
        model(8'd10, ym, r, ov);
        check("t2_latency", dc, 52);
        check("t2_y_const", yd, 40'h0000004000);
        check("t2_y_model", yd, ym);
        repeat (5) @(negedge clk);
        check("t2_y_held", y_out, ym);

        // two coefficients in the last group, negative delay wraps address
        clear_mem();
        rj_mem[15] = 8'd2; co_mem[0] = 9'h101; co_mem[1] = 9'h000;
        d_mem[0] = 16'd100; d_mem[255] = 16'd30;
        run(8'd0, 0, 0, dc, yd);
        model(8'd0, ym, r, ov);
        check("t3_latency", dc, 55);
        check("t3_y_const", yd, 40'h0000230000);
        check("t3_y_model", yd, ym);
        check("t3_daddr0", daddr_log[49], 255);
        check("t3_daddr1", daddr_log[52], 0);

        // full coefficient memory, max positive samples
        clear_mem();
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'd32;
        d_mem[8'h80] = 16'h7FFF;
        run(8'h80, 0, 0, dc, yd);
        model(8'h80, ym, r, ov);
        check("t4_latency", dc, 1585);
        check("t4_latency_model", dc, 49 + 3 * r);
        check("t4_y", yd, ym);
`ifdef CONV_OVF_EN
        check("t4_ovf", ovf_done, ov);
`endif

        // random configurations; iteration 2 pulses start mid-run
        for (int it = 0; it < 4; it++) begin
            clear_mem();
            for (int g = 0; g < 16; g++) rj_mem[g] = 8'($urandom_range(0, 4));
            for (int i = 0; i < 80; i++) co_mem[i] = 9'($urandom);
            for (int i = 0; i < 256; i++) d_mem[i] = 16'($urandom);
            n = 8'($urandom);
            run(n, 0, (it == 2) ? 10 : 0, dc, yd);
            model(n, ym, r, ov);
            check("rnd_latency", dc, 49 + 3 * r);
            check("rnd_y", yd, ym);
        end

        // coefficient overrun: sum(Rj)=640
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'd40;
        for (int i = 0; i < 512; i++) co_mem[i] = 9'($urandom);
        n = 8'($urandom);
        run(n, 0, 0, dc, yd);
        model(n, ym, r, ov);
        check("ovr_latency", dc, 1585);
        check("ovr_y", yd, ym);
        yprev = ym;

        // abort mid-run, then a clean run
        for (int g = 0; g < 16; g++) rj_mem[g] = 8'($urandom_range(1, 3));
        n = 8'($urandom);
        run(n, 20, 0, dc, yd);
        check("abort_no_done", dc, -1);
        check("abort_busy20", busy_log[20], 1);
        check("abort_busy21", busy_log[21], 0);
        check("abort_y_kept", y_out, yprev);
        run(n, 0, 0, dc, yd);
        model(n, ym, r, ov);
        check("post_abort_latency", dc, 49 + 3 * r);
        check("post_abort_y", yd, ym);

`ifdef CONV_OVF_EN
        clear_mem();
        rj_mem[0] = 8'd255; rj_mem[1] = 8'd255;
        d_mem[8'h05] = 16'h7FFF;
        run(8'h05, 0, 0, dc, yd);
        model(8'h05, ym, r, ov);
        check("ovf_model", ov, 1);
        check("ovf_set", ovf_done, 1);
        check("ovf_y", yd, ym);
`endif

        // reset mid-run
        @(negedge clk);
        start = 1'b1; n_idx = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_done", conv_done, 0);
        check("mrst_y", y_out, 0);
        check("mrst_rj_addr", rj_addr, 0);
        check("mrst_coeff_addr", coeff_addr, 0);
        check("mrst_data_addr", data_addr, 0);
        reset_n = 1'b1;
        run(8'h11, 0, 0, dc, yd);
        model(8'h11, ym, r, ov);
        check("mrst_latency", dc, 49 + 3 * r);
        check("mrst_y2", yd, ym);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
